// File: rtl/call_stack_pkg.sv
// ---------------------------------------------------------------------------
// call_stack_pkg
// Shared pipeline constants for the return-address stack, the PC mux and the
// jump-target logic.
//   STACK_DEPTH : number of return-address entries in the call stack
//   ADDR_W      : program-counter / return-address width in bits
//   PTR_W       : width of the stack pointer and of the exported entry count
// ---------------------------------------------------------------------------
package call_stack_pkg;

    localparam int STACK_DEPTH = 8;
    localparam int ADDR_W      = 13;
    localparam int PTR_W       = 4;

endpackage

// File: rtl/call_stack.sv
// ---------------------------------------------------------------------------
// call_stack
// Hardware return-address stack for subroutine calls. A call pushes PC+1, a
// return pops it, and top_addr feeds the PC mux so a return can jump straight
// to the saved address. Overflow and underflow attempts are rejected and
// recorded in sticky flags until clr_err.
//
// Ports
//   clk        : sole clock, state updates on the rising edge
//   rst        : asynchronous active-low reset
//   push       : store push_addr on top of the stack (call)
//   pop        : discard the top entry (return)
//   halt       : freeze; push, pop and clr_err are ignored
//   clr_err    : synchronous clear of the sticky error flags
//   push_addr  : return address to store
//   top_addr   : current top entry, zero when the stack is empty
//   empty      : no entries stored
//   full       : DEPTH entries stored
//   count      : number of stored entries, 0..DEPTH
//   overflow   : sticky, a push was rejected because the stack was full
//   underflow  : sticky, a pop was rejected because the stack was empty
// ---------------------------------------------------------------------------
module call_stack
    import call_stack_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int AW    = ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             halt,
    input  logic             clr_err,
    input  logic [AW-1:0]    push_addr,
    output logic [AW-1:0]    top_addr,
    output logic             empty,
    output logic             full,
    output logic [PTR_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    localparam int               IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] SP_MAX = PTR_W'(DEPTH);

    logic [AW-1:0]    storage [DEPTH];
    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] sp_next;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_en;
    logic             ovf_set;
    logic             unf_set;

    // sp counts stored entries, so the top lives one slot below it
    assign empty    = (sp == '0);
    assign full     = (sp == SP_MAX);
    assign count    = sp;
    assign top_idx  = IDX_W'(sp - PTR_W'(1));
    assign top_addr = empty ? '0 : storage[top_idx];

    // Decide this cycle's write slot, pointer move and error events.
    // Push together with pop means "replace the top", except on an empty
    // stack where there is nothing to replace and it behaves as a plain push.
    always_comb begin
        sp_next = sp;
        wr_en   = 1'b0;
        wr_idx  = IDX_W'(sp);
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (!halt) begin
            case ({push, pop})
                2'b10: begin
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        sp_next = sp + PTR_W'(1);
                    end
                end
                2'b01: begin
                    if (empty) begin
                        unf_set = 1'b1;
                    end else begin
                        sp_next = sp - PTR_W'(1);
                    end
                end
                2'b11: begin
                    wr_en = 1'b1;
                    if (empty) begin
                        sp_next = sp + PTR_W'(1);
                    end else begin
                        wr_idx = top_idx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Storage, pointer and sticky flags. A newly detected error wins over a
    // simultaneous clr_err so that no event is ever lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else begin
            sp <= sp_next;
            if (wr_en) begin
                storage[wr_idx] <= push_addr;
            end
            if (!halt) begin
                overflow  <= ovf_set | (overflow & ~clr_err);
                underflow <= unf_set | (underflow & ~clr_err);
            end
        end
    end

endmodule

// File: doc/call_stack.md
CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 Parameter DEPTH, default 8: number of return-address entries.
REQ-002 Parameter AW, default 13: return-address width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-005 push  input  1  store push_addr on top of stack; driven by controller push (call).
REQ-006 pop  input  1  discard top entry; driven by controller pop (return).
REQ-007 halt  input  1  freeze; driven by controller Halt.
REQ-008 clr_err  input  1  synchronous clear of sticky error flags.
REQ-009 push_addr  input  AW  return address (PC+1 of the call instruction).
REQ-010 top_addr  output  AW  current top entry; StackSel selects it as next PC on return.
REQ-011 empty  output  1  high when zero entries are stored.
REQ-012 full  output  1  high when DEPTH entries are stored.
REQ-013 count  output  4  number of stored entries, 0..DEPTH.
REQ-014 overflow  output  1  sticky: push rejected because stack was full.
REQ-015 underflow  output  1  sticky: pop rejected because stack was empty.

Function
REQ-016 Storage SHALL be DEPTH registers of AW bits plus a stack pointer sp (0..DEPTH) equal to count.
REQ-017 top_addr SHALL be combinational from storage[sp-1] when sp>0 and all-zero when sp==0.
REQ-018 empty, full and count SHALL be combinational decodes of sp.
REQ-019 Push only, not full: storage[sp] <= push_addr, sp <= sp+1; new top visible the cycle after the edge.
REQ-020 Pop only, not empty: sp <= sp-1; the value on top_addr during the pop cycle is the consumed return address.
REQ-021 Push and pop together, not empty: storage[sp-1] <= push_addr, sp unchanged (replace top).
REQ-022 Push and pop together, empty: SHALL act as push only; underflow not set.
REQ-023 Push only while full: storage and sp unchanged; overflow <= 1.
REQ-024 Pop only while empty: sp unchanged; underflow <= 1.
REQ-025 Push and pop together while full: replace top per REQ-021; overflow not set.
REQ-026 halt high: push, pop and clr_err ignored; all state held.
REQ-027 clr_err high, halt low: overflow and underflow <= 0 unless the same cycle sets them, in which case set wins.
REQ-028 Neither push nor pop: no state change.
REQ-029 No wrap-around: sp SHALL never exceed DEPTH or go below 0.

Reset
REQ-030 rst low SHALL asynchronously set sp=0, every storage entry=0, overflow=0 and underflow=0.
REQ-031 During and after reset: top_addr=0, empty=1, full=0, count=0.
REQ-032 Reset asserted mid-operation SHALL abort any push or pop in that cycle; no partial write.
REQ-033 First state update SHALL occur on the first rising clk edge after rst deasserts.

Structure
REQ-034 A shared pipeline package SHALL hold DEPTH, AW and the pointer width (4) for use by this block, the PC mux and the jump-target logic.
REQ-035 No sub-module; storage, pointer and flags are implemented inline.

Verification
REQ-036 Reset, push 0x0010, 0x0020, 0x0030 -> count=3, top_addr=0x0030; three pops return 0x0030, 0x0020, 0x0010, then empty=1, top_addr=0.
REQ-037 Push 8 distinct addresses, then push 0x1ABC -> full=1, overflow=1, top_addr=8th address, count=8.
REQ-038 From empty, pop -> underflow=1, count=0; clr_err -> underflow=0; pop with clr_err in the same cycle -> underflow stays 1.
REQ-039 count=2, top 0x0005; push and pop together with push_addr=0x0777 -> count=2, top_addr=0x0777; pop -> earlier entry exposed.
REQ-040 count=3, halt=1 with push and pop pulsed for 4 cycles -> count, top_addr and flags unchanged; after halt=0, push works.
REQ-041 count=5, rst low asynchronously between edges -> count=0, empty=1, top_addr=0 before the next edge; all entries read 0 after refill tests.
